// File: rtl/pipa_pkg.sv
// pipa_pkg: shared axis encoding, default timing and saturation limits for the PIPA pulse source
package pipa_pkg;
    typedef enum logic [1:0] {AX_X = 2'd0, AX_Y = 2'd1, AX_Z = 2'd2, AX_RSV = 2'd3} pipa_axis_e;
    localparam int SLOT_CLKS_DEF = 320;
    localparam int PULSE_CLKS_DEF = 8;
    localparam int DW_DEF = 12;
    localparam int PW_DEF = 16;
    function automatic int sat_max(input int pw);
        return (1 << (pw - 1)) - 1;
    endfunction
    localparam int SAT_MAX_DEF = sat_max(PW_DEF);
endpackage

// File: rtl/pipa_axis_chan.sv
// pipa_axis_chan: one axis - saturating pending count, pulse-width timer, p/m lines and sticky ovf
module pipa_axis_chan
    import pipa_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF,
    parameter int PULSE_CLKS = PULSE_CLKS_DEF
) (
    input  logic          CLOCK,
    input  logic          rst_,
    input  logic          clr,
    input  logic          add,
    input  logic          slot,
    input  logic [DW-1:0] delta,
    output logic          p,
    output logic          m,
    output logic          ovf,
    output logic          busy
);
    localparam int CW = $clog2(PULSE_CLKS + 1);
    localparam logic signed [PW:0] HI = (PW + 1)'(sat_max(PW));
    localparam logic signed [PW:0] LO = -HI;
    logic signed [PW-1:0] pend;
    logic signed [PW-1:0] pend_add;
    logic signed [PW:0]   sum;
    logic [CW-1:0]        pcnt;
    logic                 pos;
    logic                 sat_hi;
    logic                 sat_lo;
    logic                 fire;
    // one guard bit so the add cannot wrap before the limit test
    assign sum      = $signed({pend[PW-1], pend}) + $signed({{(PW + 1 - DW){delta[DW-1]}}, delta});
    assign sat_hi   = sum > HI;
    assign sat_lo   = sum < LO;
    assign pend_add = sat_hi ? HI[PW-1:0] : sat_lo ? LO[PW-1:0] : sum[PW-1:0];
    assign fire     = slot & ~add & (pend != '0);
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            pend <= '0;
            pcnt <= '0;
            pos  <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            pend <= '0;
            pcnt <= '0;
            pos  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (add) begin
                pend <= pend_add;
                ovf  <= ovf | sat_hi | sat_lo;
            end else if (fire) begin
                pend <= pend[PW-1] ? pend + 1'b1 : pend - 1'b1;
            end
            if (fire) begin
                pos  <= ~pend[PW-1];
                pcnt <= CW'(PULSE_CLKS);
            end else if (pcnt != '0) begin
                pcnt <= pcnt - 1'b1;
            end
        end
    end
    assign p    = (pcnt != '0) & pos;
    assign m    = (pcnt != '0) & ~pos;
    assign busy = (pend != '0) | (pcnt != '0);
endmodule

// File: rtl/pipa_pulse_gen.sv
// pipa_pulse_gen: ternary PIPA pulse source - slot timer, command accept and three axis channels
module pipa_pulse_gen
    import pipa_pkg::*;
#(
    parameter int SLOT_CLKS = SLOT_CLKS_DEF,
    parameter int PULSE_CLKS = PULSE_CLKS_DEF,
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          CLOCK,
    input  logic          rst_,
    input  logic          en,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_axis,
    input  logic [DW-1:0] cmd_delta,
    output logic          PIPAXp,
    output logic          PIPAXm,
    output logic          PIPAYp,
    output logic          PIPAYm,
    output logic          PIPAZp,
    output logic          PIPAZm,
    output logic          busy,
    output logic [2:0]    ovf
);
    localparam int SW = $clog2(SLOT_CLKS);
    logic [SW-1:0] slot_cnt;
    logic          slot_start;
    logic          xfer;
    pipa_axis_e    ax;
    logic [2:0]    add;
    logic [2:0]    p;
    logic [2:0]    m;
    logic [2:0]    busy_ax;
    assign slot_start = en & (slot_cnt == '0);
    // ready drops on slot_start so an accept never races a decrement
    assign cmd_ready  = rst_ & ~slot_start & ~clr;
    assign xfer       = cmd_valid & cmd_ready;
    assign ax         = pipa_axis_e'(cmd_axis);
    assign add        = {xfer & (ax == AX_Z), xfer & (ax == AX_Y), xfer & (ax == AX_X)};
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_)
            slot_cnt <= '0;
        else if (clr)
            slot_cnt <= '0;
        else if (en)
            slot_cnt <= (slot_cnt == SW'(SLOT_CLKS - 1)) ? '0 : slot_cnt + 1'b1;
    end
    for (genvar a = 0; a < 3; a++) begin : g_ax
        pipa_axis_chan #(
            .PW(PW),
            .DW(DW),
            .PULSE_CLKS(PULSE_CLKS)
        ) u_chan (
            .CLOCK(CLOCK),
            .rst_ (rst_),
            .clr  (clr),
            .add  (add[a]),
            .slot (slot_start),
            .delta(cmd_delta),
            .p    (p[a]),
            .m    (m[a]),
            .ovf  (ovf[a]),
            .busy (busy_ax[a])
        );
    end
    assign {PIPAZp, PIPAYp, PIPAXp} = p;
    assign {PIPAZm, PIPAYm, PIPAXm} = m;
    assign busy = |busy_ax;
endmodule

// File: tb/tb_pipa_pulse_gen.sv
// tb_pipa_pulse_gen: directed bench for the PIPA pulse source with a negedge pulse-train monitor
module tb_pipa_pulse_gen;
    logic        CLOCK = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_axis = 2'd0;
    logic [11:0] cmd_delta = 12'd0;
    logic        PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
    logic        busy;
    logic [2:0]  ovf;
    logic [5:0]  lines;
    int checks = 0;
    int errors = 0;
    int rises[6];
    int first_rise[6];
    int last_rise[6];
    int run[6];
    int bad_width, overlap, gap_err, cyc;
    logic [5:0] prev;
    logic mon_clr = 1'b0;
    int acc;

    pipa_pulse_gen #(.SLOT_CLKS(16), .PULSE_CLKS(4), .DW(12), .PW(16)) dut (
        .CLOCK(CLOCK), .rst_(rst_), .en(en), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_axis(cmd_axis), .cmd_delta(cmd_delta),
        .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp), .PIPAYm(PIPAYm),
        .PIPAZp(PIPAZp), .PIPAZm(PIPAZm), .busy(busy), .ovf(ovf)
    );

    always #5 CLOCK = ~CLOCK;
    assign lines = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};

    // line index: 0 Xp, 1 Xm, 2 Yp, 3 Ym, 4 Zp, 5 Zm
    initial begin
        prev = '0;
        cyc = 0;
        forever begin
            @(negedge CLOCK);
            if (mon_clr) begin
                for (int i = 0; i < 6; i++) begin
                    rises[i] = 0;
                    run[i] = 0;
                    first_rise[i] = -1;
                    last_rise[i] = -1;
                end
                bad_width = 0;
                overlap = 0;
                gap_err = 0;
                prev = '0;
            end else begin
                cyc++;
                for (int i = 0; i < 6; i++) begin
                    if (lines[i]) begin
                        if (!prev[i]) begin
                            rises[i]++;
                            if (last_rise[i] >= 0 && cyc - last_rise[i] != 16) gap_err++;
                            if (first_rise[i] < 0) first_rise[i] = cyc;
                            last_rise[i] = cyc;
                            run[i] = 1;
                        end else begin
                            run[i]++;
                        end
                    end else if (prev[i] && run[i] != 4) begin
                        bad_width++;
                    end
                end
                if ((PIPAXp & PIPAXm) | (PIPAYp & PIPAYm) | (PIPAZp & PIPAZm)) overlap++;
                prev = lines;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge CLOCK);
        #1 mon_clr = 1'b0;
        tick();
    endtask

    task automatic send(input logic [1:0] axis, input int d);
        cmd_axis = axis;
        cmd_delta = 12'(d);
        cmd_valid = 1'b1;
        for (int n = 0; n < 40 && !cmd_ready; n++) tick();
        check("send_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int n = 0; n < lim && busy; n++) tick();
        check("drain_idle", 32'(busy), 0);
        repeat (2) tick();
    endtask

    task automatic sync_slot();
        for (int n = 0; n < 40 && cmd_ready; n++) tick();
        tick();
    endtask

    initial begin
        repeat (2) tick();
        check("rst_lines", 32'(lines), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_ovf", 32'(ovf), 0);
        #2 rst_ = 1'b1;

        // Z +3: three 4-cycle Zp pulses one slot apart
        mon_reset();
        send(2'd2, 3);
        check("t1_busy_on", 32'(busy), 1);
        wait_idle(200);
        check("t1_zp", 32'(rises[4]), 3);
        check("t1_zm", 32'(rises[5]), 0);
        check("t1_width", 32'(bad_width), 0);
        check("t1_gap", 32'(gap_err), 0);

        // Y -2 then X +1 in the same slot
        mon_reset();
        sync_slot();
        send(2'd1, -2);
        send(2'd0, 1);
        wait_idle(200);
        check("t2_ym", 32'(rises[3]), 2);
        check("t2_yp", 32'(rises[2]), 0);
        check("t2_xp", 32'(rises[0]), 1);
        check("t2_xm", 32'(rises[1]), 0);
        check("t2_same_slot", 32'(first_rise[0] - first_rise[3]), 0);
        check("t2_overlap", 32'(overlap), 0);
        check("t2_width", 32'(bad_width), 0);

        // Z +5, then Z -5 after two pulses leaves -2
        mon_reset();
        sync_slot();
        send(2'd2, 5);
        for (int n = 0; n < 100 && rises[4] < 2; n++) tick();
        send(2'd2, -5);
        wait_idle(200);
        check("t3_zp", 32'(rises[4]), 2);
        check("t3_zm", 32'(rises[5]), 2);
        check("t3_overlap", 32'(overlap), 0);
        check("t3_width", 32'(bad_width), 0);

        // held valid: ready low only on slot_start cycles
        mon_reset();
        sync_slot();
        acc = 0;
        cmd_axis = 2'd0;
        cmd_delta = 12'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            check("t4_ready", 32'(cmd_ready), ((i + 1) % 16 != 0) ? 1 : 0);
            if (cmd_ready) acc++;
            tick();
        end
        cmd_valid = 1'b0;
        check("t4_acc", 32'(acc), 60);
        wait_idle(1500);
        check("t4_xp", 32'(rises[0]), 60);
        check("t4_gap", 32'(gap_err), 0);
        check("t4_width", 32'(bad_width), 0);

        // saturation on X, then synchronous clear
        mon_reset();
        for (int k = 0; k < 17; k++) send(2'd0, 2047);
        check("t5_ovf", 32'(ovf), 1);
        clr = 1'b1;
        #1 check("t5_clr_ready", 32'(cmd_ready), 0);
        tick();
        clr = 1'b0;
        #1;
        check("t5_ovf_clr", 32'(ovf), 0);
        check("t5_busy_clr", 32'(busy), 0);
        check("t5_lines_clr", 32'(lines), 0);
        check("t5_slot_restart", 32'(cmd_ready), 0);

        // asynchronous reset in the middle of a pulse
        sync_slot();
        send(2'd1, 1);
        for (int n = 0; n < 40 && !PIPAYp; n++) tick();
        check("t6_pulse_seen", 32'(PIPAYp), 1);
        #3 rst_ = 1'b0;
        #1;
        check("t6_rst_lines", 32'(lines), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_ready", 32'(cmd_ready), 0);
        #3 rst_ = 1'b1;
        mon_reset();
        repeat (40) tick();
        check("t6_no_pulse", 32'(rises[0] + rises[1] + rises[2] + rises[3] + rises[4] + rises[5]), 0);
        check("t6_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
